// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares one single-port 16-bit frame-buffer RAM between the CPU data bus
//   (read/write through the memory-mapped VGA window) and the VGA pixel
//   prefetcher (read-only). Grants are made only in IDLE. Every access ends
//   in an ACK cycle, so a request that is still high while it is being acked
//   is not granted a second time. A run counter limits how many VGA grants
//   in a row can pass a waiting CPU request.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   cs                  frame-buffer chip select from the bus decoder
//   data_m_*            CPU bus: addr, data_in, bytesel, wr_en, access (in);
//                       data_out, ack (out, registered)
//   fb_access, fb_addr  VGA prefetch read request and word address
//   fb_data, fb_ack     VGA read data (held between acks) and ack pulse
//   ram_*               RAM address/write data/byte enables/write strobe
//                       (combinational in the grant cycle); ram_rdata is
//                       valid the cycle after the address is presented
module vga_fb_arbiter #(
  parameter int addr_width  = 15,
  parameter int max_vga_run = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic [addr_width-1:0] data_m_addr,
  input  logic [15:0]           data_m_data_in,
  output logic [15:0]           data_m_data_out,
  input  logic [1:0]            data_m_bytesel,
  input  logic                  data_m_wr_en,
  input  logic                  data_m_access,
  output logic                  data_m_ack,
  input  logic                  fb_access,
  input  logic [addr_width-1:0] fb_addr,
  output logic [15:0]           fb_data,
  output logic                  fb_ack,
  output logic [addr_width-1:0] ram_addr,
  output logic [15:0]           ram_wdata,
  output logic [1:0]            ram_bytesel,
  output logic                  ram_wr_en,
  input  logic [15:0]           ram_rdata
);

  localparam int run_w = $clog2(max_vga_run + 1);
  localparam logic [run_w-1:0] run_max = run_w'(max_vga_run);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    VGA_RD = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [run_w-1:0] vga_run_r;
  logic [run_w-1:0] vga_run_next_s;
  logic             cpu_req_s;
  logic             grant_cpu_s;
  logic             grant_vga_s;

  // Arbitration: VGA wins a tie unless it has already used its run budget.
  always_comb begin
    cpu_req_s   = cs & data_m_access;
    grant_cpu_s = 1'b0;
    grant_vga_s = 1'b0;
    if (state_r == IDLE) begin
      if (cpu_req_s && (!fb_access || (vga_run_r == run_max))) begin
        grant_cpu_s = 1'b1;
      end else begin
        grant_cpu_s = 1'b0;
      end
      grant_vga_s = fb_access & ~grant_cpu_s;
    end else begin
      grant_cpu_s = 1'b0;
      grant_vga_s = 1'b0;
    end
  end

  // Next state and the RAM drive of the grant cycle; RAM is idle otherwise.
  always_comb begin
    state_next_s = state_r;
    ram_addr     = '0;
    ram_wdata    = 16'h0000;
    ram_bytesel  = 2'b00;
    ram_wr_en    = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_cpu_s) begin
          ram_addr    = data_m_addr;
          ram_wdata   = data_m_data_in;
          ram_bytesel = data_m_bytesel;
          ram_wr_en   = data_m_wr_en;
          // A write completes in the grant cycle, so it goes straight to ACK.
          state_next_s = data_m_wr_en ? ACK : CPU_RD;
        end else if (grant_vga_s) begin
          ram_addr     = fb_addr;
          ram_bytesel  = 2'b11;
          state_next_s = VGA_RD;
        end else begin
          state_next_s = IDLE;
        end
      end
      CPU_RD:  state_next_s = ACK;
      VGA_RD:  state_next_s = ACK;
      ACK:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // VGA run counter: counts VGA grants that pass a waiting CPU request.
  always_comb begin
    vga_run_next_s = vga_run_r;
    if (state_r == IDLE) begin
      if (grant_cpu_s || !cpu_req_s) begin
        vga_run_next_s = '0;
      end else if (grant_vga_s && (vga_run_r != run_max)) begin
        vga_run_next_s = vga_run_r + run_w'(1);
      end else begin
        vga_run_next_s = vga_run_r;
      end
    end else begin
      vga_run_next_s = vga_run_r;
    end
  end

  // State, run counter and registered requester outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= IDLE;
      vga_run_r       <= '0;
      data_m_ack      <= 1'b0;
      data_m_data_out <= 16'h0000;
      fb_ack          <= 1'b0;
      fb_data         <= 16'h0000;
    end else begin
      state_r    <= state_next_s;
      vga_run_r  <= vga_run_next_s;
      // Write ack is set in the grant cycle; read acks one cycle after the
      // RAM has sampled the address, together with the captured data.
      data_m_ack <= (state_r == CPU_RD) | (grant_cpu_s & data_m_wr_en);
      fb_ack     <= (state_r == VGA_RD);
      // CPU read data is only non-zero during its ack cycle.
      data_m_data_out <= (state_r == CPU_RD) ? ram_rdata : 16'h0000;
      if (state_r == VGA_RD) begin
        fb_data <= ram_rdata;
      end else begin
        fb_data <= fb_data;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs;
  logic [AW-1:0] data_m_addr;
  logic [15:0]   data_m_data_in;
  logic [15:0]   data_m_data_out;
  logic [1:0]    data_m_bytesel;
  logic          data_m_wr_en;
  logic          data_m_access;
  logic          data_m_ack;
  logic          fb_access;
  logic [AW-1:0] fb_addr;
  logic [15:0]   fb_data;
  logic          fb_ack;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic [1:0]    ram_bytesel;
  logic          ram_wr_en;
  logic [15:0]   ram_rdata;

  vga_fb_arbiter #(.addr_width(AW), .max_vga_run(4)) dut (
    .clk(clk), .reset(reset), .cs(cs),
    .data_m_addr(data_m_addr), .data_m_data_in(data_m_data_in),
    .data_m_data_out(data_m_data_out), .data_m_bytesel(data_m_bytesel),
    .data_m_wr_en(data_m_wr_en), .data_m_access(data_m_access),
    .data_m_ack(data_m_ack), .fb_access(fb_access), .fb_addr(fb_addr),
    .fb_data(fb_data), .fb_ack(fb_ack), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_bytesel(ram_bytesel),
    .ram_wr_en(ram_wr_en), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Frame-buffer RAM model: byte-enabled write, one-cycle read latency.
  logic [15:0] mem [0:(1<<AW)-1];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << AW); i++) begin
        if (i == 32'h0123)      mem[i] <= 16'h00AA;
        else if (i == 32'h4000) mem[i] <= 16'h1234;
        else                    mem[i] <= 16'(i) ^ 16'h5A5A;
      end
    end else begin
      if (ram_wr_en && ram_bytesel[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
      if (ram_wr_en && ram_bytesel[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
      ram_rdata <= mem[ram_addr];
    end
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] cpu_q[$];
  logic [15:0] vga_q[$];
  logic [15:0] last_fb = 16'h0000;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops expected data on every ack, checks idle values.
  always @(negedge clk) begin
    logic [15:0] e;
    if (reset) begin
      last_fb = 16'h0000;
    end else begin
      chk(!(data_m_ack && fb_ack), "ack_exclusive", {data_m_ack, fb_ack}, 32'h0);
      if (data_m_ack) begin
        chk(cpu_q.size() != 0, "cpu_ack_expected", 32'h1, 32'h0);
        if (cpu_q.size() != 0) begin
          e = cpu_q.pop_front();
          chk(data_m_data_out == e, "cpu_rdata", data_m_data_out, e);
        end
      end else begin
        chk(data_m_data_out == 16'h0000, "cpu_data_zero", data_m_data_out, 32'h0);
      end
      if (fb_ack) begin
        chk(vga_q.size() != 0, "fb_ack_expected", 32'h1, 32'h0);
        if (vga_q.size() != 0) begin
          e = vga_q.pop_front();
          chk(fb_data == e, "fb_rdata", fb_data, e);
          last_fb = e;
        end
      end else begin
        chk(fb_data == last_fb, "fb_data_hold", fb_data, last_fb);
      end
    end
  end

  task automatic cpu_xfer(input bit wr, input logic [AW-1:0] addr, input logic [15:0] wd,
                          input logic [1:0] be, input logic [15:0] exp);
    int lat;
    bit got;
    @(negedge clk);
    cpu_q.push_back(wr ? 16'h0000 : exp);
    cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = wr;
    data_m_addr = addr; data_m_data_in = wd; data_m_bytesel = be;
    #1;
    chk(ram_wr_en == wr, "cpu_grant_wr_en", ram_wr_en, wr);
    chk(ram_addr == addr, "cpu_grant_addr", ram_addr, addr);
    chk(ram_bytesel == be, "cpu_grant_bytesel", ram_bytesel, be);
    if (wr) chk(ram_wdata == wd, "cpu_grant_wdata", ram_wdata, wd);
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = data_m_ack;
    end
    chk(got, "cpu_ack_timeout", lat, 32'd20);
    chk(lat == (wr ? 1 : 2), "cpu_latency", lat, wr ? 32'd1 : 32'd2);
    chk(ram_wr_en == 1'b0, "wr_en_ack_cycle", ram_wr_en, 32'h0);
    data_m_access = 1'b0; cs = 1'b0;
  endtask

  task automatic vga_xfer(input logic [AW-1:0] addr, input logic [15:0] exp);
    int lat;
    bit got;
    @(negedge clk);
    vga_q.push_back(exp);
    fb_addr = addr; fb_access = 1'b1;
    #1;
    chk(ram_addr == addr, "vga_grant_addr", ram_addr, addr);
    chk(ram_bytesel == 2'b11, "vga_grant_bytesel", ram_bytesel, 32'h3);
    chk(ram_wr_en == 1'b0, "vga_grant_wr_en", ram_wr_en, 32'h0);
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = fb_ack;
    end
    chk(got, "vga_ack_timeout", lat, 32'd20);
    chk(lat == 2, "vga_latency", lat, 32'd2);
    fb_access = 1'b0;
  endtask

  typedef struct {
    bit            vga;
    bit            wr;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [1:0]    be;
    logic [15:0]   exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=%0d expected=%0d", n_tests, 0);
    $fatal(1, "bench timeout");
  end

  initial begin
    int fcnt, hold, rounds, cyc;
    bit done, first_seen;

    vecs[0] = '{1'b0, 1'b1, 15'h0123, 16'hBEEF, 2'b10, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 15'h0123, 16'h0000, 2'b11, 16'hBEAA};
    vecs[2] = '{1'b1, 1'b0, 15'h4000, 16'h0000, 2'b11, 16'h1234};
    vecs[3] = '{1'b0, 1'b1, 15'h0200, 16'hA5C3, 2'b01, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 15'h0200, 16'h0000, 2'b11, 16'h58C3};
    vecs[5] = '{1'b0, 1'b1, 15'h7FFF, 16'hFFFF, 2'b11, 16'h0000};
    vecs[6] = '{1'b1, 1'b0, 15'h7FFF, 16'h0000, 2'b11, 16'hFFFF};
    vecs[7] = '{1'b1, 1'b0, 15'h0000, 16'h0000, 2'b11, 16'h5A5A};
    vecs[8] = '{1'b0, 1'b1, 15'h0123, 16'h1111, 2'b00, 16'h0000};
    vecs[9] = '{1'b0, 1'b0, 15'h0123, 16'h0000, 2'b11, 16'hBEAA};

    reset = 1'b1; mem_init = 1'b1;
    cs = 1'b0; data_m_access = 1'b0; data_m_wr_en = 1'b0;
    data_m_addr = '0; data_m_data_in = 16'h0000; data_m_bytesel = 2'b00;
    fb_access = 1'b0; fb_addr = '0;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    chk(data_m_ack == 1'b0, "rst_data_m_ack", data_m_ack, 32'h0);
    chk(fb_ack == 1'b0, "rst_fb_ack", fb_ack, 32'h0);
    chk(data_m_data_out == 16'h0000, "rst_data_out", data_m_data_out, 32'h0);
    chk(fb_data == 16'h0000, "rst_fb_data", fb_data, 32'h0);
    reset = 1'b0;

    // Reset in the middle of a VGA read drops it; the held request is regranted.
    @(negedge clk);
    fb_addr = 15'h4000; fb_access = 1'b1;
    #1 chk(ram_addr == 15'h4000, "rstmid_first_grant", ram_addr, 32'h4000);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk(fb_ack == 1'b0, "rstmid_fb_ack", fb_ack, 32'h0);
    chk(data_m_ack == 1'b0, "rstmid_data_m_ack", data_m_ack, 32'h0);
    chk(fb_data == 16'h0000, "rstmid_fb_data", fb_data, 32'h0);
    chk(data_m_data_out == 16'h0000, "rstmid_data_out", data_m_data_out, 32'h0);
    chk(ram_addr == 15'h4000, "rstmid_state_idle", ram_addr, 32'h4000);
    repeat (2) begin
      @(negedge clk);
      chk(fb_ack == 1'b0, "rstmid_no_fb_ack", fb_ack, 32'h0);
    end
    reset = 1'b0;
    vga_q.push_back(16'h1234);
    #1 chk(ram_addr == 15'h4000 && ram_bytesel == 2'b11, "rstmid_regrant", ram_addr, 32'h4000);
    cyc = 0;
    while (!fb_ack && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk(cyc == 2, "rstmid_regrant_latency", cyc, 32'd2);
    fb_access = 1'b0;

    // Table-driven single-requester transfers.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].vga) vga_xfer(vecs[i].addr, vecs[i].exp);
      else cpu_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp);
    end

    // data_m_access without cs must be ignored.
    @(negedge clk);
    cs = 1'b0; data_m_access = 1'b1; data_m_wr_en = 1'b1;
    data_m_addr = 15'h0055; data_m_data_in = 16'hDEAD; data_m_bytesel = 2'b11;
    repeat (20) begin
      @(negedge clk);
      chk(data_m_ack == 1'b0, "nocs_no_ack", data_m_ack, 32'h0);
      chk(ram_wr_en == 1'b0, "nocs_no_write", ram_wr_en, 32'h0);
    end
    data_m_access = 1'b0; data_m_wr_en = 1'b0;
    cpu_xfer(1'b0, 15'h0055, 16'h0000, 2'b11, 16'h5A0F);

    // Simultaneous requests: VGA first; a CPU-idle IDLE cycle clears the run.
    @(negedge clk);
    repeat (7) vga_q.push_back(16'h1234);
    cpu_q.push_back(16'hBEAA);
    fb_addr = 15'h4000; fb_access = 1'b1;
    cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0; data_m_addr = 15'h0123;
    fcnt = 0; hold = 0; done = 1'b0; first_seen = 1'b0; cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (hold > 0) begin
        hold--;
        if (hold == 0) data_m_access = 1'b1;
      end
      if ((fb_ack || data_m_ack) && !first_seen) begin
        first_seen = 1'b1;
        chk(fb_ack == 1'b1, "simul_vga_first", fb_ack, 32'h1);
      end
      if (fb_ack) begin
        fcnt++;
        if (fcnt == 2) begin
          data_m_access = 1'b0;
          hold = 2;
        end
      end
      if (data_m_ack) done = 1'b1;
    end
    chk(done, "simul_cpu_ack_timeout", cyc, 32'd100);
    chk(fcnt == 7, "run_clear_vga_count", fcnt, 32'd7);
    fb_access = 1'b0; cs = 1'b0; data_m_access = 1'b0;

    // Continuous VGA traffic with a CPU read always pending: 4 VGA then 1 CPU.
    @(negedge clk);
    repeat (40) vga_q.push_back(16'h1234);
    repeat (10) cpu_q.push_back(16'hBEAA);
    fb_addr = 15'h4000; fb_access = 1'b1;
    cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0; data_m_addr = 15'h0123;
    rounds = 0; fcnt = 0; cyc = 0;
    while (rounds < 10 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (fb_ack) fcnt++;
      if (!data_m_access) begin
        data_m_access = 1'b1;
      end else if (data_m_ack) begin
        chk(fcnt == 4, "starve_vga_per_round", fcnt, 32'd4);
        fcnt = 0;
        rounds++;
        data_m_access = 1'b0;
        if (rounds == 10) begin
          fb_access = 1'b0; cs = 1'b0;
        end
      end
    end
    chk(rounds == 10, "starve_rounds", rounds, 32'd10);
    fb_access = 1'b0; cs = 1'b0; data_m_access = 1'b0;
    repeat (4) @(negedge clk);
    chk(vga_q.size() == 0, "vga_queue_drained", vga_q.size(), 32'h0);
    chk(cpu_q.size() == 0, "cpu_queue_drained", cpu_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
